pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 8-bit pipeline. It detects load-use hazards between Decode and Execute, flushes on taken branches, and runs multi-cycle RET and interrupt-entry sequences. It drives the stall/flush inputs of the Fetch/Decode latches and the Decode-to-Execute latch (FlushE, load_stallD), and issues PC-source strobes.

Parameters:
RET_MIN, 2, minimum cycles spent in RET_WAIT before return is allowed (1..7)
INT_CYCLES, 3, cycles spent in INT_SEQ (2..7)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s1D  in  2  decode source-1 register address
s2D  in  2  decode source-2 register address
valids1_D  in  1  s1D is read by the decode instruction
valids2_D  in  1  s2D is read by the decode instruction
dest_addrEX  in  2  execute destination register
reg_file_wenEX  in  2  execute register-write enables; any bit set = EX writes dest_addrEX
D_mem_renEX  in  1  execute instruction is a memory load
branch_takenEX  in  1  branch/jump resolved taken in EX
ret_D  in  1  RET/RTI in decode
ret_done  in  1  return address available from data memory
intr  in  1  level interrupt request
stallF  out  1  hold PC/fetch latch
stallD  out  1  hold F-to-D latch
FlushD  out  1  clear F-to-D latch
FlushE  out  1  clear D-to-EX latch
load_stallD  out  1  tags the inserted load-use bubble
pc_sel_ret  out  1  one-cycle strobe: load PC from return address
pc_sel_int  out  1  one-cycle strobe: load PC from interrupt vector
int_ack  out  1  one-cycle interrupt acknowledge
busy  out  1  FSM not in RUN

Behaviour:
- States: RUN, RET_WAIT, INT_SEQ. State register plus 3-bit counter cnt and 1-bit ret_seen.
- On rst_n low (async): state=RUN, cnt=0, ret_seen=0. While rst_n=0, all outputs are 0, overriding any input.
- Outputs are combinational from state/cnt and the current inputs, so stall and flush act in the same cycle the hazard is present. State updates on posedge clk.
- Load-use condition LU = D_mem_renEX & |reg_file_wenEX & ((valids1_D & s1D==dest_addrEX) | (valids2_D & s2D==dest_addrEX)).
- RUN priority, highest first:
  1. branch_takenEX: FlushD=1, FlushE=1. Stalls are 0. ret_D and intr are ignored this cycle. Stay in RUN.
  2. LU: stallF=1, stallD=1, FlushE=1, load_stallD=1 for exactly one cycle. The next cycle re-evaluates with the bubble in EX. ret_D and intr are deferred.
  3. ret_D: next state RET_WAIT, cnt<=RET_MIN-1, ret_seen<=0. This cycle: stallF=1, FlushD=1.
  4. intr: next state INT_SEQ, cnt<=INT_CYCLES-1. This cycle: int_ack=1, stallF=1, FlushD=1.
  5. Otherwise all outputs are 0.
- RET_WAIT:
  - Every cycle: stallF=1, FlushD=1, busy=1.
  - cnt decrements, saturating at 0. ret_seen is set when ret_done=1.
  - Exit when cnt==0 and (ret_done | ret_seen): pc_sel_ret=1 that cycle, next state RUN, ret_seen<=0.
  - If branch_takenEX=1 (older branch makes the RET wrong-path): FlushD=1, FlushE=1, pc_sel_ret=0, abort to RUN, clear ret_seen. Abort takes priority over exit.
  - intr is deferred until RUN.
- INT_SEQ:
  - Every cycle: stallF=1, FlushD=1, busy=1. cnt decrements each cycle.
  - When cnt==0: pc_sel_int=1, next state RUN.
  - branch_takenEX and ret_D are ignored. int_ack is not reasserted.
- intr that is still high on return to RUN is taken again per the priority rules. Request de-assertion is software's duty.
- busy=1 in RET_WAIT and INT_SEQ, and in the entry cycle of either.
- Reset mid-sequence: immediate return to RUN, no strobe emitted.

Test Plan:
- Load-use: D_mem_renEX=1, reg_file_wenEX=2'b01, dest_addrEX=2, s1D=2, valids1_D=1 -> one cycle of stallF=stallD=FlushE=load_stallD=1. Same stimulus with valids1_D=0 -> all outputs 0.
- Branch vs load-use: branch_takenEX=1 together with the LU condition -> FlushD=FlushE=1 and stallF=stallD=0.
- RET with early ret_done: ret_D pulse, then ret_done=1 on the first RET_WAIT cycle (RET_MIN=2) -> 2 cycles of stallF/FlushD in RET_WAIT, pc_sel_ret=1 on the 2nd RET_WAIT cycle, then RUN.
- RET abort: branch_takenEX=1 in the 1st RET_WAIT cycle, ret_done=1 same cycle -> pc_sel_ret=0, FlushE=1, RUN next cycle.
- Interrupt: intr=1 in RUN (INT_CYCLES=3) -> int_ack on entry cycle, 3 INT_SEQ cycles with stallF=1, pc_sel_int=1 on the last. intr asserted during RET_WAIT is taken only after pc_sel_ret.
- Async reset asserted in INT_SEQ mid-count -> outputs 0 immediately, no pc_sel_int, state RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 8-bit pipeline: load-use bubbles, branch flushes,
// and the multi-cycle RET-wait and interrupt-entry sequences.
module pipe_hazard_ctrl #(
    parameter int RET_MIN    = 2,
    parameter int INT_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] s1D,
    input  logic [1:0] s2D,
    input  logic       valids1_D,
    input  logic       valids2_D,
    input  logic [1:0] dest_addrEX,
    input  logic [1:0] reg_file_wenEX,
    input  logic       D_mem_renEX,
    input  logic       branch_takenEX,
    input  logic       ret_D,
    input  logic       ret_done,
    input  logic       intr,
    output logic       stallF,
    output logic       stallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       load_stallD,
    output logic       pc_sel_ret,
    output logic       pc_sel_int,
    output logic       int_ack,
    output logic       busy
);

    localparam logic [1:0] S_RUN      = 2'd0;
    localparam logic [1:0] S_RET_WAIT = 2'd1;
    localparam logic [1:0] S_INT_SEQ  = 2'd2;

    localparam logic [2:0] RET_LOAD = 3'(RET_MIN - 1);
    localparam logic [2:0] INT_LOAD = 3'(INT_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ret_seen_q, ret_seen_d;

    logic stall_f_c, stall_d_c, flush_d_c, flush_e_c, load_stall_c;
    logic pc_ret_c, pc_int_c, int_ack_c, busy_c;
    logic load_use;

    assign load_use = D_mem_renEX & (|reg_file_wenEX) &
                      ((valids1_D & (s1D == dest_addrEX)) |
                       (valids2_D & (s2D == dest_addrEX)));

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ret_seen_d   = ret_seen_q;
        stall_f_c    = 1'b0;
        stall_d_c    = 1'b0;
        flush_d_c    = 1'b0;
        flush_e_c    = 1'b0;
        load_stall_c = 1'b0;
        pc_ret_c     = 1'b0;
        pc_int_c     = 1'b0;
        int_ack_c    = 1'b0;
        busy_c       = 1'b0;

        case (state_q)
            S_RUN: begin
                if (branch_takenEX) begin
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (load_use) begin
                    stall_f_c    = 1'b1;
                    stall_d_c    = 1'b1;
                    flush_e_c    = 1'b1;
                    load_stall_c = 1'b1;
                end else if (ret_D) begin
                    state_d    = S_RET_WAIT;
                    cnt_d      = RET_LOAD;
                    ret_seen_d = 1'b0;
                    stall_f_c  = 1'b1;
                    flush_d_c  = 1'b1;
                    busy_c     = 1'b1;
                end else if (intr) begin
                    state_d   = S_INT_SEQ;
                    cnt_d     = INT_LOAD;
                    int_ack_c = 1'b1;
                    stall_f_c = 1'b1;
                    flush_d_c = 1'b1;
                    busy_c    = 1'b1;
                end
            end

            S_RET_WAIT: begin
                stall_f_c = 1'b1;
                flush_d_c = 1'b1;
                busy_c    = 1'b1;
                cnt_d     = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                if (ret_done) ret_seen_d = 1'b1;
                // An older taken branch means this RET was fetched down the wrong path.
                if (branch_takenEX) begin
                    flush_e_c  = 1'b1;
                    state_d    = S_RUN;
                    ret_seen_d = 1'b0;
                end else if ((cnt_q == 3'd0) && (ret_done || ret_seen_q)) begin
                    pc_ret_c   = 1'b1;
                    state_d    = S_RUN;
                    ret_seen_d = 1'b0;
                end
            end

            S_INT_SEQ: begin
                stall_f_c = 1'b1;
                flush_d_c = 1'b1;
                busy_c    = 1'b1;
                if (cnt_q == 3'd0) begin
                    pc_int_c = 1'b1;
                    state_d  = S_RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end

            default: state_d = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            cnt_q      <= 3'd0;
            ret_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ret_seen_q <= ret_seen_d;
        end
    end

    // Outputs are forced low while reset is held, whatever the inputs are doing.
    assign stallF      = rst_n & stall_f_c;
    assign stallD      = rst_n & stall_d_c;
    assign FlushD      = rst_n & flush_d_c;
    assign FlushE      = rst_n & flush_e_c;
    assign load_stallD = rst_n & load_stall_c;
    assign pc_sel_ret  = rst_n & pc_ret_c;
    assign pc_sel_int  = rst_n & pc_int_c;
    assign int_ack     = rst_n & int_ack_c;
    assign busy        = rst_n & busy_c;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table, hand sequences,
// and randomized traffic against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    localparam int RET_MIN    = 2;
    localparam int INT_CYCLES = 3;

    // Output vector order: stallF stallD FlushD FlushE load_stallD pc_sel_ret pc_sel_int int_ack busy
    localparam logic [8:0] O_STF  = 9'b1_0000_0000;
    localparam logic [8:0] O_STD  = 9'b0_1000_0000;
    localparam logic [8:0] O_FD   = 9'b0_0100_0000;
    localparam logic [8:0] O_FE   = 9'b0_0010_0000;
    localparam logic [8:0] O_LS   = 9'b0_0001_0000;
    localparam logic [8:0] O_PSR  = 9'b0_0000_1000;
    localparam logic [8:0] O_PSI  = 9'b0_0000_0100;
    localparam logic [8:0] O_ACK  = 9'b0_0000_0010;
    localparam logic [8:0] O_BUSY = 9'b0_0000_0001;
    localparam logic [8:0] O_NONE = 9'b0;
    localparam logic [8:0] O_LU   = O_STF | O_STD | O_FE | O_LS;
    localparam logic [8:0] O_WAIT = O_STF | O_FD | O_BUSY;

    typedef struct packed {
        logic [1:0] s1;
        logic       v1;
        logic [1:0] s2;
        logic       v2;
        logic [1:0] dest;
        logic [1:0] wen;
        logic       ren;
        logic       br;
        logic       retd;
        logic       rdone;
        logic       intr;
    } in_t;

    typedef struct {
        in_t        in;
        logic [8:0] exp;
        string      name;
    } vec_t;

    typedef enum int { M_RUN, M_RET, M_INT } mode_e;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0] s1D, s2D, dest_addrEX, reg_file_wenEX;
    logic valids1_D, valids2_D, D_mem_renEX, branch_takenEX, ret_D, ret_done, intr;
    logic stallF, stallD, FlushD, FlushE, load_stallD, pc_sel_ret, pc_sel_int, int_ack, busy;
    logic [8:0] act;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: which sequence we are in and how many cycles it has lasted.
    mode_e m_mode = M_RUN;
    int    m_elapsed = 0;
    bit    m_seen = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RET_MIN(RET_MIN), .INT_CYCLES(INT_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n),
        .s1D(s1D), .s2D(s2D), .valids1_D(valids1_D), .valids2_D(valids2_D),
        .dest_addrEX(dest_addrEX), .reg_file_wenEX(reg_file_wenEX),
        .D_mem_renEX(D_mem_renEX), .branch_takenEX(branch_takenEX),
        .ret_D(ret_D), .ret_done(ret_done), .intr(intr),
        .stallF(stallF), .stallD(stallD), .FlushD(FlushD), .FlushE(FlushE),
        .load_stallD(load_stallD), .pc_sel_ret(pc_sel_ret), .pc_sel_int(pc_sel_int),
        .int_ack(int_ack), .busy(busy)
    );

    assign act = {stallF, stallD, FlushD, FlushE, load_stallD, pc_sel_ret, pc_sel_int, int_ack, busy};

    function automatic in_t mkin(int s1, int v1, int s2, int v2, int dest, int wen,
                                 int ren, int br, int retd, int rdone, int irq);
        in_t x;
        x.s1 = 2'(s1); x.v1 = 1'(v1); x.s2 = 2'(s2); x.v2 = 1'(v2);
        x.dest = 2'(dest); x.wen = 2'(wen); x.ren = 1'(ren); x.br = 1'(br);
        x.retd = 1'(retd); x.rdone = 1'(rdone); x.intr = 1'(irq);
        return x;
    endfunction

    function automatic bit is_lu(in_t x);
        return x.ren && (x.wen != 2'b00) &&
               ((x.v1 && x.s1 == x.dest) || (x.v2 && x.s2 == x.dest));
    endfunction

    function automatic logic [8:0] model_eval(in_t x);
        logic [8:0] o = O_NONE;
        case (m_mode)
            M_RUN: begin
                if (x.br)            o = O_FD | O_FE;
                else if (is_lu(x))   o = O_LU;
                else if (x.retd)     o = O_WAIT;
                else if (x.intr)     o = O_WAIT | O_ACK;
            end
            M_RET: begin
                o = O_WAIT;
                if (x.br) o |= O_FE;
                else if (m_elapsed >= RET_MIN - 1 && (x.rdone || m_seen)) o |= O_PSR;
            end
            M_INT: begin
                o = O_WAIT;
                if (m_elapsed == INT_CYCLES - 1) o |= O_PSI;
            end
            default: o = O_NONE;
        endcase
        return o;
    endfunction

    task automatic model_reset();
        m_mode = M_RUN; m_elapsed = 0; m_seen = 1'b0;
    endtask

    task automatic model_advance(in_t x);
        if (!rst_n) begin
            model_reset();
            return;
        end
        case (m_mode)
            M_RUN: if (!x.br && !is_lu(x)) begin
                if (x.retd)      begin m_mode = M_RET; m_elapsed = 0; m_seen = 1'b0; end
                else if (x.intr) begin m_mode = M_INT; m_elapsed = 0; end
            end
            M_RET: begin
                if (x.br || (m_elapsed >= RET_MIN - 1 && (x.rdone || m_seen))) begin
                    m_mode = M_RUN; m_seen = 1'b0;
                end else begin
                    m_elapsed++;
                    if (x.rdone) m_seen = 1'b1;
                end
            end
            M_INT: if (m_elapsed == INT_CYCLES - 1) m_mode = M_RUN; else m_elapsed++;
            default: model_reset();
        endcase
    endtask

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (stF stD fD fE ls psr psi ack busy)", name, got, exp);
        end
    endtask

    task automatic set_in(in_t x);
        s1D = x.s1; valids1_D = x.v1; s2D = x.s2; valids2_D = x.v2;
        dest_addrEX = x.dest; reg_file_wenEX = x.wen; D_mem_renEX = x.ren;
        branch_takenEX = x.br; ret_D = x.retd; ret_done = x.rdone; intr = x.intr;
    endtask

    // Called just after a rising edge; checks mid-cycle, then advances through the next edge.
    task automatic step(input in_t x, input logic [8:0] exp, input string name);
        set_in(x);
        @(negedge clk);
        check(name, act, exp);
        @(posedge clk);
        model_advance(x);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(mkin(1, 1, 1, 1, 1, 3, 1, 0, 1, 1, 1));
        #2;
        check("reset_outputs_zero", act, O_NONE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    vec_t tbl[12];
    in_t  idle;

    initial begin
        idle  = mkin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        set_in(idle);
        @(posedge clk);
        #1;
        do_reset();

        tbl[0]  = '{mkin(2,1,0,0,2,1,1,0,0,0,0), O_LU,          "lu_s1"};
        tbl[1]  = '{mkin(2,0,0,0,2,1,1,0,0,0,0), O_NONE,        "lu_valid_off"};
        tbl[2]  = '{mkin(0,0,3,1,3,2,1,0,0,0,0), O_LU,          "lu_s2"};
        tbl[3]  = '{mkin(2,1,0,0,2,0,1,0,0,0,0), O_NONE,        "lu_no_wen"};
        tbl[4]  = '{mkin(2,1,0,0,2,1,0,0,0,0,0), O_NONE,        "lu_no_load"};
        tbl[5]  = '{mkin(2,1,0,0,2,1,1,1,0,0,0), O_FD | O_FE,   "branch_over_lu"};
        tbl[6]  = '{mkin(2,1,0,0,2,1,1,0,1,0,1), O_LU,          "lu_defers_ret_intr"};
        tbl[7]  = '{mkin(0,0,0,0,0,0,0,0,1,0,0), O_WAIT,        "ret_entry"};
        tbl[8]  = '{mkin(0,0,0,0,0,0,0,0,0,0,1), O_WAIT | O_ACK,"intr_entry"};
        tbl[9]  = '{mkin(0,0,0,0,0,0,0,0,1,0,1), O_WAIT,        "ret_over_intr"};
        tbl[10] = '{mkin(0,0,0,0,0,0,0,1,1,0,1), O_FD | O_FE,   "branch_over_intr"};
        tbl[11] = '{mkin(1,1,1,1,2,3,1,0,0,0,0), O_NONE,        "lu_addr_miss"};

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].in, tbl[i].exp, tbl[i].name);
            do_reset();
        end

        // RET with ret_done on the first wait cycle.
        step(mkin(0,0,0,0,0,0,0,0,1,0,0), O_WAIT,         "ret_early_entry");
        step(mkin(0,0,0,0,0,0,0,0,0,1,0), O_WAIT,         "ret_early_wait1");
        step(idle,                        O_WAIT | O_PSR, "ret_early_wait2_pc");
        step(idle,                        O_NONE,         "ret_early_run");

        // RET aborted by an older taken branch; abort beats a simultaneous ret_done.
        step(mkin(0,0,0,0,0,0,0,0,1,0,0), O_WAIT,         "ret_abort_entry");
        step(mkin(0,0,0,0,0,0,0,1,0,1,0), O_WAIT | O_FE,  "ret_abort_branch");
        step(idle,                        O_NONE,         "ret_abort_run");

        // Interrupt entry and full INT_SEQ.
        step(mkin(0,0,0,0,0,0,0,0,0,0,1), O_WAIT | O_ACK, "int_entry");
        step(mkin(0,0,0,0,0,0,0,1,1,0,0), O_WAIT,         "int_seq1_ignores_br_ret");
        step(idle,                        O_WAIT,         "int_seq2");
        step(idle,                        O_WAIT | O_PSI, "int_seq3_pc");
        step(idle,                        O_NONE,         "int_run");

        // Interrupt raised during RET_WAIT is taken only after pc_sel_ret.
        step(mkin(0,0,0,0,0,0,0,0,1,0,0), O_WAIT,         "ret_intr_entry");
        step(mkin(0,0,0,0,0,0,0,0,0,0,1), O_WAIT,         "ret_intr_wait1");
        step(mkin(0,0,0,0,0,0,0,0,0,1,1), O_WAIT | O_PSR, "ret_intr_wait2_pc");
        step(mkin(0,0,0,0,0,0,0,0,0,0,1), O_WAIT | O_ACK, "ret_intr_int_entry");
        step(idle,                        O_WAIT,         "ret_intr_seq1");
        step(idle,                        O_WAIT,         "ret_intr_seq2");
        step(idle,                        O_WAIT | O_PSI, "ret_intr_seq3_pc");

        // Async reset in the middle of INT_SEQ.
        step(mkin(0,0,0,0,0,0,0,0,0,0,1), O_WAIT | O_ACK, "intrst_entry");
        step(idle,                        O_WAIT,         "intrst_seq1");
        set_in(mkin(0,0,0,0,0,0,0,0,0,0,1));
        #2;
        check("intrst_seq2_before_reset", act, O_WAIT);
        rst_n = 1'b0;
        #1;
        check("intrst_async_zero", act, O_NONE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(idle, O_NONE, "intrst_run1");
        step(idle, O_NONE, "intrst_run2_no_psi");
        step(idle, O_NONE, "intrst_run3");

        // Randomized traffic against the reference model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            in_t x;
            logic [8:0] e;
            x.s1    = 2'($urandom_range(0, 3));
            x.s2    = 2'($urandom_range(0, 3));
            x.dest  = 2'($urandom_range(0, 3));
            x.v1    = 1'($urandom_range(0, 1));
            x.v2    = 1'($urandom_range(0, 1));
            x.wen   = 2'($urandom_range(0, 3));
            x.ren   = ($urandom_range(0, 3) == 0);
            x.br    = ($urandom_range(0, 7) == 0);
            x.retd  = ($urandom_range(0, 5) == 0);
            x.rdone = ($urandom_range(0, 3) == 0);
            x.intr  = ($urandom_range(0, 7) == 0);
            rst_n   = ($urandom_range(0, 99) != 0);
            e = rst_n ? model_eval(x) : O_NONE;
            step(x, e, $sformatf("random_%0d", c));
            rst_n = 1'b1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
